mux_4to1_reg: RTL and testbench

- Parameterised 4:1 data-path multiplexer with a 2-bit select.
- Output is either combinational or registered, chosen by a parameter.
- Used as a generic steering element in the memory-hierarchy datapath, e.g. cache-way and port data selection.
- Shares the system clock and reset so the registered variant drops into pipelined paths.

---
 rtl/mux_4to1_reg_pkg.sv | 17 +
 rtl/mux_4to1_core.sv | 30 +++
 rtl/mux_4to1_reg.sv | 51 +++++
 tb/tb_mux_4to1_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mux_4to1_reg_pkg.sv
// Shared constants for the 4:1 steering multiplexer: select codes,
// default data width, and the clock period used by benches.

`ifndef CYCLE
`define CYCLE 10
`endif

package mux_4to1_reg_pkg;

    localparam logic [1:0] SEL_D1 = 2'd0;
    localparam logic [1:0] SEL_D2 = 2'd1;
    localparam logic [1:0] SEL_D3 = 2'd2;
    localparam logic [1:0] SEL_D4 = 2'd3;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/mux_4to1_core.sv
// Purely combinational 4:1 selection. A select carrying X/Z drives an
// all-X result in simulation; synthesis is free to fold that branch into
// the din4 path.

module mux_4to1_core
    import mux_4to1_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    input  logic [DATA_WIDTH-1:0] din4,
    output logic [DATA_WIDTH-1:0] dout
);

    // Full decode of the select; the default only catches non-0/1 codes.
    always_comb begin
        dout = {DATA_WIDTH{1'bx}};
        case (sel)
            SEL_D1:  dout = din1;
            SEL_D2:  dout = din2;
            SEL_D3:  dout = din3;
            SEL_D4:  dout = din4;
            default: dout = {DATA_WIDTH{1'bx}};
        endcase
    end

endmodule

// File: rtl/mux_4to1_reg.sv
// 4:1 datapath steering mux with optional output register.
// OUT_REG=0: dout follows the core combinationally, clk/rst_n unused.
// OUT_REG=1: dout is a flop reloaded every clk edge, cleared
// asynchronously while rst_n is low.

module mux_4to1_reg
    import mux_4to1_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit OUT_REG    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            sel,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic [DATA_WIDTH-1:0] din3,
    input  logic [DATA_WIDTH-1:0] din4,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mux_out;

    mux_4to1_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .sel  (sel),
        .din1 (din1),
        .din2 (din2),
        .din3 (din3),
        .din4 (din4),
        .dout (mux_out)
    );

    if (OUT_REG) begin : g_reg
        // One-cycle output register, no enable, async clear.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout <= {DATA_WIDTH{1'b0}};
            end else begin
                dout <= mux_out;
            end
        end
    end else begin : g_comb
        // Clock and reset have no function in the combinational variant.
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst_n;
        assign dout           = mux_out;
    end

endmodule

// File: tb/tb_mux_4to1_reg.sv
// Bench for mux_4to1_reg: combinational and registered variants at 8 and
// 32 bits, driven from shared 32-bit data. A per-cycle compare process
// checks all four instances against a behavioural model; directed checks
// pin the model to literal values.

`ifndef CYCLE
`define CYCLE 10
`endif

module tb_mux_4to1_reg;

    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [31:0] d1, d2, d3, d4;

    logic [7:0]  comb8, reg8;
    logic [31:0] comb32, reg32;

    int n_tests = 0;
    int n_fail  = 0;
    bit run_cmp = 0;

    // Registered-path model state: inputs seen at the last clean edge.
    bit          valid = 0;
    logic [1:0]  cap_sel;
    logic [31:0] cap_d1, cap_d2, cap_d3, cap_d4;

    localparam logic [7:0]  E8  [4] = '{8'hA0, 8'hB0, 8'hC0, 8'hD0};
    localparam logic [31:0] E32 [4] = '{32'h0AA0, 32'h0BB0, 32'h0CC0, 32'h0DD0};

    mux_4to1_reg #(.DATA_WIDTH(8), .OUT_REG(1'b0)) u_comb8 (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .din1(d1[7:0]), .din2(d2[7:0]), .din3(d3[7:0]), .din4(d4[7:0]),
        .dout(comb8));

    mux_4to1_reg #(.DATA_WIDTH(8), .OUT_REG(1'b1)) u_reg8 (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .din1(d1[7:0]), .din2(d2[7:0]), .din3(d3[7:0]), .din4(d4[7:0]),
        .dout(reg8));

    mux_4to1_reg #(.DATA_WIDTH(32), .OUT_REG(1'b0)) u_comb32 (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .din1(d1), .din2(d2), .din3(d3), .din4(d4),
        .dout(comb32));

    mux_4to1_reg #(.DATA_WIDTH(32), .OUT_REG(1'b1)) u_reg32 (
        .clk(clk), .rst_n(rst_n), .sel(sel),
        .din1(d1), .din2(d2), .din3(d3), .din4(d4),
        .dout(reg32));

    initial clk = 1'b0;
    always #(`CYCLE/2) clk = ~clk;

    function automatic logic [31:0] model_mux(input logic [1:0] s,
                                              input logic [31:0] a, b, c, d);
        logic [31:0] arr [4];
        arr = '{a, b, c, d};
        return arr[s];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            valid   = 1'b1;
            cap_sel = sel;
            cap_d1  = d1;
            cap_d2  = d2;
            cap_d3  = d3;
            cap_d4  = d4;
        end else begin
            valid = 1'b0;
        end
    end

    always @(negedge rst_n) valid = 1'b0;

    // Per-cycle compare away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            logic [31:0] now_exp, reg_exp;
            now_exp = model_mux(sel, d1, d2, d3, d4);
            reg_exp = (valid && rst_n) ? model_mux(cap_sel, cap_d1, cap_d2, cap_d3, cap_d4) : 32'h0;
            check("cyc_comb8",  {24'h0, comb8}, {24'h0, now_exp[7:0]});
            check("cyc_comb32", comb32, now_exp);
            check("cyc_reg8",   {24'h0, reg8},  {24'h0, reg_exp[7:0]});
            check("cyc_reg32",  reg32, reg_exp);
        end
    end

    initial begin
        #(`CYCLE * 2000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        sel   = 2'd0;
        d1 = E32[0]; d2 = E32[1]; d3 = E32[2]; d4 = E32[3];
        #1;
        check("reset_reg8",  {24'h0, reg8}, 32'h0);
        check("reset_reg32", reg32, 32'h0);
        run_cmp = 1;

        // Combinational stepping, registered outputs held in reset.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            sel = 2'(i);
            #1;
            check("comb8_step",  {24'h0, comb8}, {24'h0, E8[i]});
            check("comb32_step", comb32, E32[i]);
            check("reg8_in_rst", {24'h0, reg8}, 32'h0);
        end

        // Selected input change propagates at once; others are ignored.
        @(posedge clk); #2;
        sel = 2'd2;
        #1;
        d3 = 32'h0000_005A;
        #1;
        check("comb8_din3_follow", {24'h0, comb8}, 32'h5A);
        check("comb32_din3_follow", comb32, 32'h5A);
        d1 = 32'hFFFF_FFFF; d2 = 32'h1234_5678; d4 = 32'h5555_5555;
        #1;
        check("comb8_other_din", {24'h0, comb8}, 32'h5A);
        d1 = E32[0]; d2 = E32[1]; d3 = E32[2]; d4 = E32[3];

        // Release reset with sel=1: first load only on the next edge.
        @(posedge clk); #2;
        sel   = 2'd1;
        rst_n = 1'b1;
        #1;
        check("reg8_before_first_edge", {24'h0, reg8}, 32'h0);
        @(posedge clk); #1;
        check("reg8_first_load",  {24'h0, reg8}, 32'hB0);
        check("reg32_first_load", reg32, 32'h0BB0);

        // One-cycle lag through the register.
        for (int i = 0; i < 4; i++) begin
            #1;
            sel = 2'(i);
            #1;
            check("reg8_holds_prev", {24'h0, reg8}, {24'h0, (i == 0) ? 8'hB0 : E8[i-1]});
            @(posedge clk); #1;
            check("reg8_lag",  {24'h0, reg8}, {24'h0, E8[i]});
            check("reg32_lag", reg32, E32[i]);
        end

        // Async clear between edges, reload on the next edge.
        #1;
        rst_n = 1'b0;
        #1;
        check("reg8_async_clr",  {24'h0, reg8}, 32'h0);
        check("reg32_async_clr", reg32, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        check("reg8_clr_held", {24'h0, reg8}, 32'h0);
        @(posedge clk); #1;
        check("reg8_reload",  {24'h0, reg8}, 32'hD0);
        check("reg32_reload", reg32, 32'h0DD0);

        // A few more directed vectors for the per-cycle compare.
        d1 = 32'hDEAD_BEEF; d2 = 32'h0000_0001; d3 = 32'h8000_0000; d4 = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            sel = 2'(3 - i);
        end
        @(posedge clk); #1;
        check("reg32_wide_d1", reg32, 32'hDEAD_BEEF);
        check("reg8_wide_d1",  {24'h0, reg8}, 32'hEF);
        @(negedge clk); #1;
        run_cmp = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
